// File: rtl/alu_arbiter_if.sv
// Handshake and ALU bus bundle for alu_arbiter. The master modport is the arbiter side.
// ALU_ERR_DETECT_EN adds the rsp_err response bit.
`timescale 1ns/1ps

interface alu_arbiter_if #(
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_ready;
  logic [7:0]        req0_opcode;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [7:0]        req1_opcode;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;

  logic [7:0]        alu_opcode;
  logic [DATA_W-1:0] alu_in1;
  logic [DATA_W-1:0] alu_in2;
  logic [DATA_W-1:0] alu_result;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
`ifdef ALU_ERR_DETECT_EN
  logic              rsp_err;
`endif

  modport master (
`ifdef ALU_ERR_DETECT_EN
    output rsp_err,
`endif
    input  req0_valid, req0_opcode, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    output req1_ready,
    output alu_opcode, alu_in1, alu_in2,
    input  alu_result,
    output rsp_valid, rsp_id, rsp_data,
    input  rsp_ready
  );

  modport slave (
`ifdef ALU_ERR_DETECT_EN
    input  rsp_err,
`endif
    output req0_valid, req0_opcode, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_opcode, req1_a, req1_b,
    input  req1_ready,
    input  alu_opcode, alu_in1, alu_in2,
    output alu_result,
    input  rsp_valid, rsp_id, rsp_data,
    output rsp_ready
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU: grant, execute, respond.
// Optional macro ALU_ERR_DETECT_EN adds rsp_err flagging undefined opcodes and divide by zero.
`timescale 1ns/1ps

module alu_arbiter #(
  parameter int DATA_W  = 8,
  parameter int FAIR_RR = 1
) (
  input  logic          clk,
  input  logic          rst,
  alu_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  // Bit 5 set tri-states the ALU output so the result bus is free while idle.
  localparam logic [7:0] PARK_OP = 8'h20;

  state_t            state;
  logic              last_grant;
  logic [7:0]        alu_opcode_q;
  logic [DATA_W-1:0] alu_in1_q;
  logic [DATA_W-1:0] alu_in2_q;
  logic              rsp_valid_q;
  logic              rsp_id_q;
  logic [DATA_W-1:0] rsp_data_q;

  logic              sel1;
  logic              accept;
  logic [7:0]        sel_opcode;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sel1       = bus.req1_valid;
    sel_opcode = bus.req0_opcode;
    sel_a      = bus.req0_a;
    sel_b      = bus.req0_b;
    if (bus.req0_valid && bus.req1_valid) begin
      sel1 = (FAIR_RR != 0) ? ~last_grant : 1'b0;
    end
    if (sel1) begin
      sel_opcode = bus.req1_opcode;
      sel_a      = bus.req1_a;
      sel_b      = bus.req1_b;
    end
  end

  // Ready is only offered in IDLE, and never while reset is held.
  assign bus.req0_ready = !rst && (state == IDLE) && bus.req0_valid && !sel1;
  assign bus.req1_ready = !rst && (state == IDLE) && bus.req1_valid &&  sel1;
  assign accept         = bus.req0_ready || bus.req1_ready;

`ifdef ALU_ERR_DETECT_EN
  logic rsp_err_q;

  function automatic logic op_err(input logic [7:0] op, input logic [DATA_W-1:0] b);
    logic undefined_op;
    logic div_zero;
    undefined_op = (op[3:0] >= 4'hB);
    div_zero     = ((op[3:0] == 4'h9) || (op[3:0] == 4'hA)) && (b == '0);
    return undefined_op || div_zero;
  endfunction
`endif

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      alu_opcode_q <= PARK_OP;
      alu_in1_q    <= '0;
      alu_in2_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
`ifdef ALU_ERR_DETECT_EN
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_opcode_q <= {sel_opcode[7:6], 1'b0, sel_opcode[4:0]};
            alu_in1_q    <= sel_a;
            alu_in2_q    <= sel_b;
            rsp_id_q     <= sel1;
            last_grant   <= sel1;
            state        <= EXEC;
          end
        end
        EXEC: begin
          rsp_data_q   <= bus.alu_result;
          rsp_valid_q  <= 1'b1;
          alu_opcode_q <= PARK_OP;
`ifdef ALU_ERR_DETECT_EN
          rsp_err_q    <= op_err(alu_opcode_q, alu_in2_q);
`endif
          state        <= RESP;
        end
        RESP: begin
          // Holding here until the consumer takes the response means it is never overwritten.
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_opcode = alu_opcode_q;
  assign bus.alu_in1    = alu_in1_q;
  assign bus.alu_in2    = alu_in2_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
`ifdef ALU_ERR_DETECT_EN
  assign bus.rsp_err    = rsp_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a transaction-level model checked every cycle plus directed literal checks.
`timescale 1ns/1ps

module tb_alu_arbiter;
  localparam int DATA_W  = 8;
  localparam int FAIR_RR = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(DATA_W)) bus ();

  alu_arbiter #(.DATA_W(DATA_W), .FAIR_RR(FAIR_RR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for the DUT (t=%0t)", name, $time);
  endtask

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 8 mul, 9 div, A mod, others 0.
  // While parked it returns a marker so a mistimed capture is visible.
  function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    if (op[5]) return 8'hEE;
    case (op[3:0])
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h8: return 8'(a * b);
      4'h9: return (b == 0) ? 8'h00 : a / b;
      4'hA: return (b == 0) ? 8'h00 : a % b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb bus.alu_result = alu_fn(bus.alu_opcode, bus.alu_in1, bus.alu_in2);

  function automatic logic spec_err(input logic [7:0] op, input logic [7:0] b);
    int code;
    code = int'(op[3:0]);
    return (code >= 11) || ((code == 9 || code == 10) && b == 0);
  endfunction

  function automatic logic pick1(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return (FAIR_RR != 0) ? !last : 1'b0;
    return v1;
  endfunction

  // Transaction model: one op is in flight from accept until its response is taken.
  logic       m_live = 1'b0;
  logic       m_busy, m_pending, m_last, m_id, m_err;
  logic [7:0] m_op, m_a, m_b, m_data;

  always @(posedge clk) begin
    if (rst) begin
      m_live    <= 1'b1;
      m_busy    <= 1'b0;
      m_pending <= 1'b0;
      m_last    <= 1'b1;
    end else if (m_live) begin
      if (m_pending) begin
        if (bus.rsp_ready) begin
          m_pending <= 1'b0;
          m_busy    <= 1'b0;
        end
      end else if (m_busy) begin
        m_pending <= 1'b1;
        m_data    <= alu_fn(m_op, m_a, m_b);
        m_err     <= spec_err(m_op, m_b);
      end else if (bus.req0_valid || bus.req1_valid) begin
        if (pick1(bus.req0_valid, bus.req1_valid, m_last)) begin
          m_id <= 1'b1; m_last <= 1'b1;
          m_op <= bus.req1_opcode & 8'hDF; m_a <= bus.req1_a; m_b <= bus.req1_b;
        end else begin
          m_id <= 1'b0; m_last <= 1'b0;
          m_op <= bus.req0_opcode & 8'hDF; m_a <= bus.req0_a; m_b <= bus.req0_b;
        end
        m_busy <= 1'b1;
      end
    end
  end

  logic g1, exp_r0, exp_r1;
  always @(negedge clk) begin
    if (m_live) begin
      g1     = pick1(bus.req0_valid, bus.req1_valid, m_last);
      exp_r0 = !rst && !m_busy && bus.req0_valid && !g1;
      exp_r1 = !rst && !m_busy && bus.req1_valid &&  g1;
      check("req0_ready", bus.req0_ready, exp_r0);
      check("req1_ready", bus.req1_ready, exp_r1);
      check("alu_opcode", bus.alu_opcode, (m_busy && !m_pending) ? m_op : 8'h20);
      check("rsp_valid", bus.rsp_valid, m_pending);
      if (m_busy && !m_pending) begin
        check("alu_in1", bus.alu_in1, m_a);
        check("alu_in2", bus.alu_in2, m_b);
      end
      if (m_pending) begin
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_data", bus.rsp_data, m_data);
`ifdef ALU_ERR_DETECT_EN
        check("rsp_err", bus.rsp_err, m_err);
`endif
      end
    end
  end

  task automatic drive(input logic id, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b);
    if (id) begin
      bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end else begin
      bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end
  endtask

  // Returns just after the accepting edge, with the request withdrawn.
  task automatic wait_accept(input logic id);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((id ? bus.req1_ready : bus.req0_ready) === 1'b1) begin
        @(posedge clk);
        #1;
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
        return;
      end
    end
    timeout("accept");
  endtask

  // Returns at the first falling edge with rsp_valid high.
  task automatic wait_rsp(output logic [7:0] data, output logic id, output logic err);
    data = 8'hXX; id = 1'bx; err = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) begin
        data = bus.rsp_data;
        id   = bus.rsp_id;
`ifdef ALU_ERR_DETECT_EN
        err  = bus.rsp_err;
`else
        err  = 1'b0;
`endif
        return;
      end
    end
    timeout("response");
  endtask

  task automatic run_op(input logic id, input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] data, output logic err);
    logic rid;
    drive(id, op, a, b);
    wait_accept(id);
    wait_rsp(data, rid, err);
    check("run_op_id", rid, id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] d;
  logic       rid, e;

  initial begin
    bus.rsp_ready = 1'b0;
    drive(1'b0, 8'h00, 8'd1, 8'd2);
    drive(1'b1, 8'h02, 8'd3, 8'd4);

    // Reset held two cycles with both requesters valid.
    repeat (2) begin
      @(negedge clk);
      check("rst_req0_ready", bus.req0_ready, 1'b0);
      check("rst_req1_ready", bus.req1_ready, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_alu_opcode", bus.alu_opcode, 8'h20);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    @(negedge clk);
    check("post_rst_opcode", bus.alu_opcode, 8'h20);
    check("post_rst_rsp_id", bus.rsp_id, 1'b0);
    check("post_rst_rsp_data", bus.rsp_data, 8'h00);
    check("post_rst_in1", bus.alu_in1, 8'h00);

    // Single ADD from req0.
    bus.rsp_ready = 1'b1;
    drive(1'b0, 8'h00, 8'd100, 8'd27);
    wait_accept(1'b0);
    @(negedge clk);
    check("add_exec_opcode", bus.alu_opcode, 8'h00);
    check("add_exec_valid", bus.rsp_valid, 1'b0);
    @(negedge clk);
    check("add_rsp_valid", bus.rsp_valid, 1'b1);
    check("add_rsp_data", bus.rsp_data, 8'd127);
    check("add_rsp_id", bus.rsp_id, 1'b0);
    @(negedge clk);
    check("add_idle_valid", bus.rsp_valid, 1'b0);
    check("add_idle_opcode", bus.alu_opcode, 8'h20);

    // Contention after a fresh reset: req0 must win first, then strict alternation.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    drive(1'b0, 8'h01, 8'd9, 8'd4);
    drive(1'b1, 8'h02, 8'hF0, 8'h3C);
    for (int k = 0; k < 6; k++) begin
      wait_rsp(d, rid, e);
      check("rr_id", rid, k % 2);
      check("rr_data", d, (k % 2) ? 8'h30 : 8'h05);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;

    // Backpressure while req1 waits, then a bit5 opcode from req1.
    bus.rsp_ready = 1'b0;
    drive(1'b0, 8'h00, 8'd3, 8'd4);
    wait_accept(1'b0);
    drive(1'b1, 8'h28, 8'h07, 8'h06);
    wait_rsp(d, rid, e);
    check("bp_first_data", d, 8'd7);
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", bus.rsp_valid, 1'b1);
      check("bp_hold_data", bus.rsp_data, 8'd7);
      check("bp_hold_id", bus.rsp_id, 1'b0);
      check("bp_req1_ready", bus.req1_ready, 1'b0);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_still_blocked", bus.req1_ready, 1'b0);
    @(negedge clk);
    check("bp_req1_accept", bus.req1_ready, 1'b1);
    @(posedge clk); #1 bus.req1_valid = 1'b0;
    @(negedge clk);
    check("mask_alu_opcode", bus.alu_opcode, 8'h08);
    check("mask_alu_in1", bus.alu_in1, 8'h07);
    wait_rsp(d, rid, e);
    check("mask_rsp_data", d, 8'd42);
    check("mask_rsp_id", rid, 1'b1);

    // Nothing requested: the ALU stays parked.
    repeat (4) @(negedge clk);
    check("idle_parked", bus.alu_opcode, 8'h20);

    // Divide and undefined-opcode cases.
    run_op(1'b0, 8'h09, 8'd10, 8'd0, d, e);
    check("div0_data", d, 8'h00);
`ifdef ALU_ERR_DETECT_EN
    check("div0_err", e, 1'b1);
`endif
    run_op(1'b1, 8'h0C, 8'd5, 8'd5, d, e);
    check("undef_data", d, 8'h00);
`ifdef ALU_ERR_DETECT_EN
    check("undef_err", e, 1'b1);
`endif
    run_op(1'b0, 8'h09, 8'd10, 8'd3, d, e);
    check("div_data", d, 8'd3);
`ifdef ALU_ERR_DETECT_EN
    check("div_err", e, 1'b0);
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
